// File: rtl/threshold.sv
// Streaming pixel binarizer: one registered stage, pixel >= threshold maps to
// HIGH_VAL, otherwise LOW_VAL. Output valid mirrors input valid one clock later.
module threshold #(
  parameter int unsigned                DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]      HIGH_VAL   = {DATA_WIDTH{1'b1}},
  parameter logic [DATA_WIDTH-1:0]      LOW_VAL    = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic [DATA_WIDTH-1:0] threshold_val,
  output logic                  data_out_valid,
  output logic [DATA_WIDTH-1:0] pixel_out
);

  logic                  valid_r;
  logic [DATA_WIDTH-1:0] pixel_r;
  logic [DATA_WIDTH-1:0] bin_s;
  logic [DATA_WIDTH-1:0] pixel_next_s;

  // Binarize against the live threshold; pixel register holds when no valid input.
  always_comb begin
    bin_s        = LOW_VAL;
    pixel_next_s = pixel_r;
    if (pixel_in >= threshold_val) begin
      bin_s = HIGH_VAL;
    end else begin
      bin_s = LOW_VAL;
    end
    if (data_valid) begin
      pixel_next_s = bin_s;
    end else begin
      pixel_next_s = pixel_r;
    end
  end

  // Output stage registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      pixel_r <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_r <= data_valid;
      pixel_r <= pixel_next_s;
    end
  end

  assign data_out_valid = valid_r;
  assign pixel_out      = pixel_r;

endmodule

// File: tb/tb_threshold.sv
// Self-checking bench for threshold: per-cycle reference model and in-order
// scoreboard, plus directed vectors with literal expectations.
module tb_threshold;

  logic       clk;
  logic       rst_n;
  logic       data_valid;
  logic [7:0] pixel_in;
  logic [7:0] threshold_val;
  logic       data_out_valid;
  logic [7:0] pixel_out;

  int errors = 0;
  int checks = 0;
  int out_cnt = 0;

  logic       m_valid;
  logic [7:0] m_pix;
  logic [7:0] exp_q[$];

  threshold #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .pixel_in(pixel_in),
    .threshold_val(threshold_val), .data_out_valid(data_out_valid), .pixel_out(pixel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: output valid is last cycle's input valid; pixel follows the rule.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pix   <= 8'd0;
      exp_q.delete();
    end else begin
      m_valid <= data_valid;
      if (data_valid) begin
        m_pix <= (int'(pixel_in) >= int'(threshold_val)) ? 8'd255 : 8'd0;
        exp_q.push_back((int'(pixel_in) >= int'(threshold_val)) ? 8'd255 : 8'd0);
      end
    end
  end

  // Per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    check("model_valid", int'(data_out_valid), int'(m_valid));
    check("model_pixel", int'(pixel_out), int'(m_pix));
    if (data_out_valid && rst_n) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        check("scoreboard_order", int'(pixel_out), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One valid cycle, then idle; checks the result and the valid drop.
  task automatic pulse(input string name, input int pix, input int thr, input int exp_v);
    data_valid    = 1'b1;
    pixel_in      = 8'(pix);
    threshold_val = 8'(thr);
    step();
    data_valid = 1'b0;
    pixel_in   = 8'd0;
    check({name, "_valid"}, int'(data_out_valid), 1);
    check({name, "_pix"}, int'(pixel_out), exp_v);
    step();
    check({name, "_drop"}, int'(data_out_valid), 0);
    check({name, "_hold"}, int'(pixel_out), exp_v);
  endtask

  int pix_set[10] = '{0, 50, 100, 127, 128, 129, 150, 200, 254, 255};
  int start_cnt;
  int n_img;

  initial begin
    rst_n = 1'b0; data_valid = 1'b0; pixel_in = 8'd200; threshold_val = 8'd128;
    // Reset held while valid input toggles.
    for (int i = 0; i < 6; i++) begin
      data_valid = (i % 2 == 0);
      step();
      check("rst_valid", int'(data_out_valid), 0);
      check("rst_pix", int'(pixel_out), 0);
    end
    data_valid = 1'b0;
    rst_n = 1'b1;
    check("rst_release_valid", int'(data_out_valid), 0);
    check("rst_release_pix", int'(pixel_out), 0);
    step();
    pulse("first_after_rst", 200, 128, 255);

    // Threshold sweeps.
    for (int i = 0; i < 10; i++) pulse("thr128", pix_set[i], 128, (pix_set[i] >= 128) ? 255 : 0);
    for (int i = 0; i < 10; i++) pulse("thr0", pix_set[i], 0, 255);
    for (int i = 0; i < 10; i++) pulse("thr255", pix_set[i], 255, (pix_set[i] == 255) ? 255 : 0);

    // Streaming alternating 127/128.
    start_cnt = out_cnt;
    threshold_val = 8'd128;
    for (int i = 0; i < 10; i++) begin
      data_valid = 1'b1;
      pixel_in   = (i % 2 == 0) ? 8'd127 : 8'd128;
      step();
      check("stream_valid", int'(data_out_valid), 1);
      check("stream_pix", int'(pixel_out), (i % 2 == 0) ? 0 : 255);
    end
    data_valid = 1'b0;
    step();
    check("stream_drop", int'(data_out_valid), 0);
    check("stream_hold", int'(pixel_out), 255);
    step();
    check("stream_count", out_cnt - start_cnt, 10);

    // Threshold change between consecutive pixels.
    data_valid = 1'b1; pixel_in = 8'd100; threshold_val = 8'd128;
    step();
    check("thrchg_a", int'(pixel_out), 0);
    threshold_val = 8'd100;
    step();
    check("thrchg_b", int'(pixel_out), 255);
    data_valid = 1'b0;
    step();

    // Reset mid-stream discards the in-flight result.
    data_valid = 1'b1; pixel_in = 8'd250; threshold_val = 8'd10;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(data_out_valid), 0);
    check("midrst_pix", int'(pixel_out), 0);
    step();
    rst_n = 1'b1; pixel_in = 8'd20;
    step();
    data_valid = 1'b0;
    check("post_midrst", int'(pixel_out), 255);
    step();

    // Image run with gaps, threshold 128.
    n_img = 40 * 58;
    start_cnt = out_cnt;
    threshold_val = 8'd128;
    for (int i = 0; i < n_img; i++) begin
      data_valid = 1'b1;
      pixel_in   = 8'($urandom_range(0, 255));
      step();
      data_valid = 1'b0;
      repeat ($urandom_range(1, 2)) step();
    end
    repeat (3) step();
    check("image_count", out_cnt - start_cnt, n_img);
    check("image_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
